// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding comparator for one E-stage source register.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardE
);

  // M result wins over W result; x0 is never forwarded
  always_comb begin
    ForwardE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
      ForwardE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
      ForwardE = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubble, redirect flush
// and data-memory wait handling with a sticky timeout flag.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [1:0]  LOAD_SRC    = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       PCSrcE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  hazState_t        state;
  hazState_t        nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             lu;
  logic             br;
  logic             miss;

  hazard_fwd_unit uFwdA (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (ForwardAE)
  );

  hazard_fwd_unit uFwdB (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (ForwardBE)
  );

  assign lu   = (ResultSrcE == LOAD_SRC) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign br   = (PCSrcE != 2'b00);
  assign miss = dmem_req && !dmem_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Next state and hazard priority: memory miss, then redirect, then load-use
  always_comb begin
    nextState = state;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;

    case (state)
      RUN:      if (miss)       nextState = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) nextState = RUN;
      default:                  nextState = RUN;
    endcase

    if (miss) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (br) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Wait counter and sticky timeout; the FSM keeps waiting after timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      if (miss) begin
        waitCnt <= '0;
      end
    end else begin
      if (waitCnt != TIMEOUT_V) begin
        waitCnt <= waitCnt + CNT_W'(1);
      end
      if (waitCnt >= (TIMEOUT_V - CNT_W'(1))) begin
        mem_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of front-end stall cycles and E-stage flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (FlushE && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random
// vectors against a behavioural reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned TMO = 4;
  localparam logic [1:0]  LD  = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, PCSrcE;
  logic       RegWriteM, RegWriteW, dmem_req, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  // reference model state
  bit mInWait;
  int mWait;
  bit mTmo;
  int mStall;
  int mFlush;

  // expected combinational outputs for the current inputs
  bit eStallF, eStallD, eStallE, eStallM, eFlushD, eFlushE;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .LOAD_SRC(LD)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdExp(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset();
    mInWait = 1'b0;
    mWait   = 0;
    mTmo    = 1'b0;
    mStall  = 0;
    mFlush  = 0;
  endtask

  task automatic clearInputs();
    rst = 1'b0;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = '0; PCSrcE = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Apply current inputs for one cycle: check outputs mid-cycle, then advance the model.
  task automatic step(input string tag);
    bit lu, br, miss;
    vectors++;
    #1;
    if (rst) modelReset();
    lu   = (ResultSrcE == LD) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    br   = (PCSrcE != 2'b00);
    miss = dmem_req && !dmem_ready;
    eStallE = miss;
    eStallM = miss;
    eStallF = miss || (!br && lu);
    eStallD = eStallF;
    eFlushD = !miss && br;
    eFlushE = !miss && (br || lu);

    chk({tag, ".StallF"},  16'(StallF),      16'(eStallF));
    chk({tag, ".StallD"},  16'(StallD),      16'(eStallD));
    chk({tag, ".StallE"},  16'(StallE),      16'(eStallE));
    chk({tag, ".StallM"},  16'(StallM),      16'(eStallM));
    chk({tag, ".FlushD"},  16'(FlushD),      16'(eFlushD));
    chk({tag, ".FlushE"},  16'(FlushE),      16'(eFlushE));
    chk({tag, ".FwdA"},    16'(ForwardAE),   16'(fwdExp(Rs1E)));
    chk({tag, ".FwdB"},    16'(ForwardBE),   16'(fwdExp(Rs2E)));
    chk({tag, ".timeout"}, 16'(mem_timeout), 16'(mTmo));
    chk({tag, ".waiting"}, 16'(dut.state == MEM_WAIT), 16'(mInWait));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stallCnt"}, stall_cnt, 16'(mStall));
    chk({tag, ".flushCnt"}, flush_cnt, 16'(mFlush));
`endif

    @(posedge clk);
    if (!rst) begin
      if (eStallF && mStall < 65535) mStall++;
      if (eFlushE && mFlush < 65535) mFlush++;
      if (mInWait) begin
        if (mWait < int'(TMO)) mWait++;
        if (mWait >= int'(TMO)) mTmo = 1'b1;
        if (dmem_ready) mInWait = 1'b0;
      end else if (miss) begin
        mInWait = 1'b1;
        mWait   = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    clearInputs();

    // reset state
    rst = 1'b1;
    step("reset");
    chk("reset.timeout0", 16'(mem_timeout), 16'd0);
    clearInputs();
    step("idle");

    // forwarding: M wins over W, RdM=0 falls back to W
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    step("fwdM");
    RdM = 5'd0;
    #1 chk("fwdW.direct", 16'(ForwardAE), 16'(2'b01));
    step("fwdW");
    clearInputs();

    // load-use: one bubble, then E holds the bubble
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1 chk("lu.direct", 16'({StallF, StallD, FlushE}), 16'(3'b111));
    step("lu");
    ResultSrcE = 2'b00; RdE = 5'd0;
    #1 chk("lu.after", 16'({StallF, StallD, FlushE}), 16'(3'b000));
    step("luAfter");

    // redirect overrides load-use
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 2'b01;
    #1 chk("br.direct", 16'({FlushD, FlushE, StallF}), 16'(3'b110));
    step("brLu");
    clearInputs();

    // memory miss for 3 cycles, then ready
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("miss");
    dmem_ready = 1'b1;
    #1 chk("ready.noStall", 16'(StallF), 16'd0);
    step("ready");
    clearInputs();
    step("backRun");

    // timeout after TMO wait cycles, sticky across ready, cleared by reset
    dmem_req = 1'b1;
    for (int i = 0; i < int'(TMO) + 1; i++) step("tmoWait");
    #1 chk("tmo.set", 16'(mem_timeout), 16'd1);
    step("tmoHold");
    dmem_ready = 1'b1;
    step("tmoReady");
    clearInputs();
    step("tmoSticky");
    chk("tmo.sticky", 16'(mem_timeout), 16'd1);
    rst = 1'b1;
    step("tmoRst");
    chk("tmo.cleared", 16'(mem_timeout), 16'd0);
    clearInputs();

    // reset in the middle of a wait returns to RUN at once
    dmem_req = 1'b1;
    step("rstWait0");
    step("rstWait1");
    rst = 1'b1;
    #1 chk("rstWait.run", 16'(dut.state == MEM_WAIT), 16'd0);
    step("rstWait2");
    clearInputs();

    // two load-use stalls and one redirect
    rst = 1'b1;
    step("perfRst");
    clearInputs();
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    step("perfLu1");
    clearInputs();
    step("perfBubble");
    ResultSrcE = 2'b01; RdE = 5'd9; Rs2D = 5'd9;
    step("perfLu2");
    clearInputs();
    PCSrcE = 2'b10;
    step("perfBr");
    clearInputs();
    step("perfIdle");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall", stall_cnt, 16'd2);
    chk("perf.flush", flush_cnt, 16'd3);
`endif

    // random vectors
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom % 64) == 0;
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      RegWriteM  = 1'($urandom % 2);
      RegWriteW  = 1'($urandom % 2);
      dmem_req   = ($urandom % 3) == 0;
      dmem_ready = 1'($urandom % 2);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
